// File: rtl/wb_pkg.sv
// Shared writeback definitions: datapath widths (common with the register
// file), the queue entry layout and the hard-wired zero register.
package wb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  // Register 0 reads as zero; writes to it are dropped.
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Shift-compacting result queue for the multiply/divide unit. Entry 0 is
// always the oldest. Supports a head pop, an address squash and a tail push
// in the same cycle, and reports whether two probe addresses hit a valid
// entry.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enq_valid,
  input  logic [ADDR_WIDTH-1:0]        enq_address,
  input  logic [DATA_WIDTH-1:0]        enq_data,
  input  logic                         deq,
  input  logic                         squash_valid,
  input  logic [ADDR_WIDTH-1:0]        squash_address,
  input  logic [ADDR_WIDTH-1:0]        check_address_1,
  input  logic [ADDR_WIDTH-1:0]        check_address_2,
  output wb_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         match_1,
  output logic                         match_2
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  wb_entry_t        entry_q    [DEPTH];
  wb_entry_t        entry_next [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;

  // Drop popped and squashed entries, slide survivors down in order, then
  // append the new result behind them.
  always_comb begin
    logic [CW-1:0] wr;
    logic          keep;
    wr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_next[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      keep = entry_q[i].valid
             && !(deq && (i == 0))
             && !(squash_valid && (entry_q[i].address == squash_address));
      if (keep) begin
        entry_next[wr[IW-1:0]] = entry_q[i];
        wr = wr + CW'(1);
      end
    end
    // The producer only pushes while count_q < DEPTH, so a slot is free.
    if (enq_valid) begin
      entry_next[wr[IW-1:0]] = '{valid: 1'b1, address: enq_address, data: enq_data};
      wr = wr + CW'(1);
    end
    count_next = wr;
  end

  // Queue storage and occupancy register.
  // NOTE: the entries are plain flops, not RAM, so clearing them on reset is
  // cheap and keeps stale valid bits from raising hazards after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_next[i];
      end
      count_q <= count_next;
    end
  end

  // Probe the valid entries for pending writes to the decode sources.
  always_comb begin
    match_1 = 1'b0;
    match_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_q[i].valid && (entry_q[i].address == check_address_1)) match_1 = 1'b1;
      if (entry_q[i].valid && (entry_q[i].address == check_address_2)) match_2 = 1'b1;
    end
  end

  assign head  = entry_q[0];
  assign count = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results (never stalled) with queued or
// bypassed multiply results onto the single register-file write port, and
// flags decode hazards against queued and in-flight writes.
module writeback_arbiter
  import wb_pkg::wb_entry_t;
  import wb_pkg::ZERO_REG;
#(
  // Widths must match wb_pkg, which sizes the queue entries.
  parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [ADDR_WIDTH-1:0]       alu_address,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  input  logic                        mul_valid,
  output logic                        mul_ready,
  input  logic [ADDR_WIDTH-1:0]       mul_address,
  input  logic [DATA_WIDTH-1:0]       mul_data,
  input  logic [ADDR_WIDTH-1:0]       check_address_1,
  input  logic [ADDR_WIDTH-1:0]       check_address_2,
  output logic                        hazard_1,
  output logic                        hazard_2,
  output logic [ADDR_WIDTH-1:0]       write_address,
  output logic [DATA_WIDTH-1:0]       write_data_in,
  output logic                        WriteEnable,
  output logic [$clog2(DEPTH+1)-1:0]  pending_count
);

  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t             head;
  logic                  q_match_1;
  logic                  q_match_2;
  logic                  mul_fire;
  logic                  deq;
  logic                  bypass;
  logic                  enq_valid;
  logic                  squash_valid;
  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [DATA_WIDTH-1:0] sel_data;

  // Ready depends only on the registered count, so a full queue stays
  // closed even in a cycle where it drains.
  assign mul_ready    = (pending_count < CW'(DEPTH));
  assign mul_fire     = mul_valid && mul_ready;
  // A younger ALU write makes any queued write to the same register stale.
  assign squash_valid = alu_valid && (alu_address != ZERO_REG);
  // Register-0 multiply results are accepted and discarded.
  assign enq_valid    = mul_fire && !bypass && (mul_address != ZERO_REG);

  // Priority select: ALU, then oldest queued result, then bypass.
  always_comb begin
    sel_valid   = 1'b0;
    sel_address = ZERO_REG;
    sel_data    = '0;
    deq         = 1'b0;
    bypass      = 1'b0;
    if (alu_valid) begin
      sel_valid   = 1'b1;
      sel_address = alu_address;
      sel_data    = alu_data;
    end else if (head.valid) begin
      sel_valid   = 1'b1;
      sel_address = head.address;
      sel_data    = head.data;
      deq         = 1'b1;
    end else if (mul_fire) begin
      sel_valid   = 1'b1;
      sel_address = mul_address;
      sel_data    = mul_data;
      bypass      = 1'b1;
    end
  end

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock           (clock),
    .reset           (reset),
    .enq_valid       (enq_valid),
    .enq_address     (mul_address),
    .enq_data        (mul_data),
    .deq             (deq),
    .squash_valid    (squash_valid),
    .squash_address  (alu_address),
    .check_address_1 (check_address_1),
    .check_address_2 (check_address_2),
    .head            (head),
    .count           (pending_count),
    .match_1         (q_match_1),
    .match_2         (q_match_2)
  );

  // Register the selected write; register 0 never asserts the enable.
  // NOTE: non-blocking assignments here so every flop samples the pre-edge
  // values of the select logic, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      WriteEnable   <= 1'b0;
      write_address <= '0;
      write_data_in <= '0;
    end else begin
      WriteEnable <= sel_valid && (sel_address != ZERO_REG);
      if (sel_valid) begin
        write_address <= sel_address;
        write_data_in <= sel_data;
      end
    end
  end

  assign hazard_1 = (check_address_1 != ZERO_REG)
                    && (q_match_1 || (WriteEnable && (write_address == check_address_1)));
  assign hazard_2 = (check_address_2 != ZERO_REG)
                    && (q_match_2 || (WriteEnable && (write_address == check_address_2)));

endmodule
